// File: rtl/alu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared constants for the registered ALU control decoder: ALUControl
// encodings, ALUop codes, the R-type opcode, funct7 classes and the FSM
// state type used by alu_ctrl_seq.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

  // ALUControl encodings
  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_AND    = 4'b0010;
  localparam logic [3:0] ALU_OR     = 4'b0011;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_SLT    = 4'b0101;
  localparam logic [3:0] ALU_SLTU   = 4'b0110;
  localparam logic [3:0] ALU_SLL    = 4'b0111;
  localparam logic [3:0] ALU_SRL    = 4'b1000;
  localparam logic [3:0] ALU_SRA    = 4'b1001;
  localparam logic [3:0] ALU_MUL    = 4'b1010;
  localparam logic [3:0] ALU_MULH   = 4'b1011;
  localparam logic [3:0] ALU_MULHSU = 4'b1100;
  localparam logic [3:0] ALU_MULHU  = 4'b1101;
  localparam logic [3:0] ALU_DIV    = 4'b1110;  // funct3[0] picks DIV/DIVU downstream
  localparam logic [3:0] ALU_REM    = 4'b1111;  // funct3[0] picks REM/REMU downstream

  // ALUop codes from the main control decoder
  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_ARITH  = 2'b10;
  localparam logic [1:0] ALUOP_RSVD   = 2'b11;

  localparam logic [6:0] OP_R = 7'b0110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_VALID = 2'b10
  } state_e;

  // R-type funct7 values the core understands at all
  function automatic logic is_known_r_funct7(input logic [6:0] f7);
    return (f7 == F7_BASE) || (f7 == F7_ALT) || (f7 == F7_MULDIV);
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// -----------------------------------------------------------------------------
// alu_ctrl_decode
// Purely combinational ALUop/op/funct3/funct7 -> ALUControl decode.
// Configuration macro: ALU_CTRL_RV32M_EN (adds RV32M decode and the
// o_is_md / o_is_div outputs; without it M encodings are flagged illegal).
// Ports:
//   i_alu_op   [1:0]  ALUop from the main decoder
//   i_op       [6:0]  opcode
//   i_funct3   [2:0]  funct3
//   i_funct7   [6:0]  funct7
//   o_alu_ctrl [3:0]  decoded ALUControl
//   o_illegal         unsupported combination (ALUControl forced to ADD)
//   o_is_md           M-extension op (RV32M build only)
//   o_is_div          DIV/REM family, selects the div latency (RV32M build only)
// -----------------------------------------------------------------------------
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output logic [3:0] o_alu_ctrl,
  output logic       o_illegal
`ifdef ALU_CTRL_RV32M_EN
  ,
  output logic       o_is_md,
  output logic       o_is_div
`endif
);

  logic w_r_type;

  assign w_r_type = (i_op == OP_R);

  // Decode table; the M check comes first because funct7=0000001 would
  // otherwise fall into the base-integer funct3 table.
  always_comb begin
    o_alu_ctrl = ALU_ADD;
    o_illegal  = 1'b0;
`ifdef ALU_CTRL_RV32M_EN
    o_is_md    = 1'b0;
    o_is_div   = 1'b0;
`endif
    case (i_alu_op)
      ALUOP_MEM:    o_alu_ctrl = ALU_ADD;
      ALUOP_BRANCH: o_alu_ctrl = ALU_SUB;
      ALUOP_ARITH: begin
        if (w_r_type && (i_funct7 == F7_MULDIV)) begin
`ifdef ALU_CTRL_RV32M_EN
          o_is_md  = 1'b1;
          o_is_div = i_funct3[2];
          case (i_funct3)
            3'b000:  o_alu_ctrl = ALU_MUL;
            3'b001:  o_alu_ctrl = ALU_MULH;
            3'b010:  o_alu_ctrl = ALU_MULHSU;
            3'b011:  o_alu_ctrl = ALU_MULHU;
            3'b100:  o_alu_ctrl = ALU_DIV;
            3'b101:  o_alu_ctrl = ALU_DIV;
            default: o_alu_ctrl = ALU_REM;
          endcase
`else
          o_illegal = 1'b1;
`endif
        end else if (w_r_type && !is_known_r_funct7(i_funct7)) begin
          o_illegal = 1'b1;
        end else begin
          case (i_funct3)
            // I-type addi has op[5]=0, so a stray funct7[5] never makes it SUB
            3'b000:  o_alu_ctrl = ({i_op[5], i_funct7[5]} == 2'b11) ? ALU_SUB : ALU_ADD;
            3'b001:  o_alu_ctrl = ALU_SLL;
            3'b010:  o_alu_ctrl = ALU_SLT;
            3'b011:  o_alu_ctrl = ALU_SLTU;
            3'b100:  o_alu_ctrl = ALU_XOR;
            3'b101:  o_alu_ctrl = i_funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  o_alu_ctrl = ALU_OR;
            3'b111:  o_alu_ctrl = ALU_AND;
            default: o_alu_ctrl = ALU_ADD;
          endcase
        end
      end
      ALUOP_RSVD: o_illegal = 1'b1;
      default:    o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// -----------------------------------------------------------------------------
// alu_ctrl_seq
// Registered, valid/ready-handshaked ALU control decoder. Non-M ops complete
// in one cycle; M ops stall in WAIT for MUL_LAT/DIV_LAT cycles while a
// one-cycle md_start strobe kicks the iterative mul/div unit.
// Configuration macro: ALU_CTRL_RV32M_EN (without it there is no WAIT state
// or counter, md_start/busy are tied low and MUL_LAT/DIV_LAT are ignored).
// Ports:
//   clk, rst           clock (rising edge), async active-low reset
//   in_valid/in_ready  request handshake
//   ALUop, op, funct3, funct7   instruction fields to decode
//   out_valid/out_ready         result handshake
//   ALUControl, illegal         registered result, qualified by out_valid
//   md_start           one-cycle start strobe to the mul/div unit
//   busy               high while waiting on the mul/div unit
// -----------------------------------------------------------------------------
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] ALUop,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] ALUControl,
  output logic       md_start,
  output logic       illegal,
  output logic       busy
);

  state_e     r_state;
  logic       r_out_valid;
  logic [3:0] r_alu_ctrl;
  logic       r_illegal;
  logic [3:0] w_dec_ctrl;
  logic       w_dec_illegal;
  logic       w_accept;

`ifdef ALU_CTRL_RV32M_EN
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  logic             w_dec_md;
  logic             w_dec_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_md_start;
  logic             r_busy;
`endif

  alu_ctrl_decode u_decode (
    .i_alu_op   (ALUop),
    .i_op       (op),
    .i_funct3   (funct3),
    .i_funct7   (funct7),
    .o_alu_ctrl (w_dec_ctrl),
    .o_illegal  (w_dec_illegal)
`ifdef ALU_CTRL_RV32M_EN
    ,
    .o_is_md    (w_dec_md),
    .o_is_div   (w_dec_div)
`endif
  );

  // VALID accepts only when its own result leaves on the same edge
  assign in_ready   = rst & ((r_state == ST_IDLE) | ((r_state == ST_VALID) & out_ready));
  assign w_accept   = in_valid & in_ready;
  assign out_valid  = r_out_valid;
  assign ALUControl = r_alu_ctrl;
  assign illegal    = r_illegal;

`ifdef ALU_CTRL_RV32M_EN
  // Gated by rst so the strobe drops in the same instant reset asserts
  assign md_start = r_md_start & rst;
  assign busy     = r_busy;
`else
  assign md_start = 1'b0;
  assign busy     = 1'b0;
`endif

  // Control FSM, stall counter and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_alu_ctrl  <= ALU_ADD;
      r_illegal   <= 1'b0;
`ifdef ALU_CTRL_RV32M_EN
      r_cnt       <= '0;
      r_md_start  <= 1'b0;
      r_busy      <= 1'b0;
`endif
    end else if (w_accept) begin
      // Accept is only possible from IDLE or a draining VALID
      r_alu_ctrl <= w_dec_ctrl;
      r_illegal  <= w_dec_illegal;
`ifdef ALU_CTRL_RV32M_EN
      if (w_dec_md) begin
        r_state     <= ST_WAIT;
        r_out_valid <= 1'b0;
        r_md_start  <= 1'b1;
        r_busy      <= 1'b1;
        r_cnt       <= w_dec_div ? DIV_LOAD : MUL_LOAD;
      end else
`endif
      begin
        r_state     <= ST_VALID;
        r_out_valid <= 1'b1;
      end
    end else begin
      case (r_state)
`ifdef ALU_CTRL_RV32M_EN
        ST_WAIT: begin
          r_md_start <= 1'b0;
          // Loaded only on WAIT entry and left at 0 on exit, so it never wraps
          if (r_cnt == '0) begin
            r_state     <= ST_VALID;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
`endif
        ST_VALID: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end else begin
            r_state <= ST_VALID;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_seq
// Directed scenario tasks plus a randomized run checked against a
// transaction-level reference (decode table + accept-edge latency model).
// Works with ALU_CTRL_RV32M_EN defined or undefined.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_seq;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;
`ifdef ALU_CTRL_RV32M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_BR = 7'b1100011;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] ALUop;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] ALUControl;
  logic       md_start;
  logic       illegal;
  logic       busy;

  int n_checks;
  int n_pass;

  alu_ctrl_seq #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUop      (ALUop),
    .op         (op),
    .funct3     (funct3),
    .funct7     (funct7),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUControl (ALUControl),
    .md_start   (md_start),
    .illegal    (illegal),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] a, input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    ALUop = a; op = o; funct3 = f3; funct7 = f7;
  endtask

  // Reference decode straight from the ALUControl table; lat = edges from accept to out_valid
  task automatic ref_dec(input logic [1:0] a, input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                         output logic [3:0] c, output logic ill, output logic md, output int lat);
    logic [3:0] base [8];
    base = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    c = 4'd0; ill = 1'b0; md = 1'b0; lat = 0;
    if (a == 2'b00) c = 4'd0;
    else if (a == 2'b01) c = 4'd1;
    else if (a == 2'b11) ill = 1'b1;
    else if (o == OPC_R && f7 == 7'h01) begin
      if (M_EN) begin
        md  = 1'b1;
        c   = (f3 < 3'd4) ? 4'd10 + {1'b0, f3} : (f3[1] ? 4'd15 : 4'd14);
        lat = (f3 < 3'd4) ? MUL_LAT : DIV_LAT;
      end else begin
        ill = 1'b1;
      end
    end else if (o == OPC_R && f7 != 7'h00 && f7 != 7'h20) ill = 1'b1;
    else begin
      c = base[f3];
      if (f3 == 3'd0 && o[5] && f7[5]) c = 4'd1;
      if (f3 == 3'd5 && f7[5]) c = 4'd9;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_op(2'b00, OPC_LD, 3'd0, 7'd0);
    #12;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (ALUControl !== 4'h0) $display("FAIL reset_alu_ctrl: got %h want 0", ALUControl); else n_pass++;
    n_checks++; if (illegal !== 1'b0) $display("FAIL reset_illegal: got %b want 0", illegal); else n_pass++;
    n_checks++; if (md_start !== 1'b0) $display("FAIL reset_md_start: got %b want 0", md_start); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    edge_step();
  endtask

  task automatic test_stream();
    logic [1:0] a  [4] = '{2'b00, 2'b10, 2'b10, 2'b10};
    logic [6:0] o  [4] = '{OPC_LD, OPC_R, OPC_R, OPC_R};
    logic [2:0] f3 [4] = '{3'd2, 3'd0, 3'd5, 3'd3};
    logic [6:0] f7 [4] = '{7'h00, 7'h20, 7'h20, 7'h00};
    logic [3:0] ex [4] = '{4'h0, 4'h1, 4'h9, 4'h6};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_op(a[i], o[i], f3[i], f7[i]);
      in_valid = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); else n_pass++;
      edge_step();
      n_checks++; if (out_valid !== 1'b1 || ALUControl !== ex[i])
        $display("FAIL stream_out[%0d]: got valid=%b ctrl=%h want valid=1 ctrl=%h", i, out_valid, ALUControl, ex[i]); else n_pass++;
    end
    in_valid = 1'b0;
    edge_step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL stream_drain: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_mul();
    out_ready = 1'b1;
    set_op(2'b10, OPC_R, 3'd0, 7'h01);
    in_valid = 1'b1;
    #1;
    edge_step();
    in_valid = 1'b0;
`ifdef ALU_CTRL_RV32M_EN
    for (int c = 1; c <= MUL_LAT; c++) begin
      #1;
      n_checks++; if (md_start !== (c == 1)) $display("FAIL mul_md_start[c%0d]: got %b want %b", c, md_start, (c == 1)); else n_pass++;
      n_checks++; if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0)
        $display("FAIL mul_wait[c%0d]: got busy=%b valid=%b in_ready=%b want 1,0,0", c, busy, out_valid, in_ready); else n_pass++;
      edge_step();
    end
    n_checks++; if (out_valid !== 1'b1 || ALUControl !== 4'hA || busy !== 1'b0 || md_start !== 1'b0)
      $display("FAIL mul_done: got valid=%b ctrl=%h busy=%b md=%b want 1,a,0,0", out_valid, ALUControl, busy, md_start); else n_pass++;
`else
    n_checks++; if (out_valid !== 1'b1 || ALUControl !== 4'h0 || illegal !== 1'b1 || md_start !== 1'b0 || busy !== 1'b0)
      $display("FAIL mul_disabled: got valid=%b ctrl=%h ill=%b md=%b busy=%b want 1,0,1,0,0",
               out_valid, ALUControl, illegal, md_start, busy); else n_pass++;
`endif
    edge_step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mul_drain: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_op(2'b10, OPC_I, 3'd4, 7'h00);
    in_valid = 1'b1;
    edge_step();
    set_op(2'b10, OPC_R, 3'd7, 7'h00);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (out_valid !== 1'b1 || ALUControl !== 4'h4 || in_ready !== 1'b0)
        $display("FAIL bp_hold[%0d]: got valid=%b ctrl=%h in_ready=%b want 1,4,0", i, out_valid, ALUControl, in_ready); else n_pass++;
      edge_step();
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", in_ready); else n_pass++;
    edge_step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || ALUControl !== 4'h2)
      $display("FAIL bp_and_captured: got valid=%b ctrl=%h want 1,2", out_valid, ALUControl); else n_pass++;
    edge_step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_drain: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_illegal();
    logic [1:0] a  [3] = '{2'b11, 2'b10, 2'b10};
    logic [6:0] f7 [3] = '{7'h00, 7'h02, 7'h01};
    int n = M_EN ? 2 : 3;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      set_op(a[i], OPC_R, 3'd6, f7[i]);
      in_valid = 1'b1;
      edge_step();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || illegal !== 1'b1 || ALUControl !== 4'h0 || busy !== 1'b0)
        $display("FAIL illegal[%0d]: got valid=%b ill=%b ctrl=%h busy=%b want 1,1,0,0", i, out_valid, illegal, ALUControl, busy); else n_pass++;
      edge_step();
    end
  endtask

  task automatic test_reset_mid_op();
    bit saw_valid = 1'b0;
    out_ready = 1'b1;
`ifdef ALU_CTRL_RV32M_EN
    // Reset while the start strobe is up
    set_op(2'b10, OPC_R, 3'd0, 7'h01);
    in_valid = 1'b1;
    edge_step();
    in_valid = 1'b0;
    #1;
    n_checks++; if (md_start !== 1'b1) $display("FAIL rstmid_md_pre: got %b want 1", md_start); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (md_start !== 1'b0 || busy !== 1'b0) $display("FAIL rstmid_md_drop: got md=%b busy=%b want 0,0", md_start, busy); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    edge_step();
    // Reset deep in a divide, counter at 10
    set_op(2'b10, OPC_R, 3'd5, 7'h01);
    in_valid = 1'b1;
    edge_step();
    in_valid = 1'b0;
    repeat (DIV_LAT - 11) edge_step();
    n_checks++; if (busy !== 1'b1 || out_valid !== 1'b0) $display("FAIL rstmid_div_wait: got busy=%b valid=%b want 1,0", busy, out_valid); else n_pass++;
`else
    out_ready = 1'b0;
    set_op(2'b10, OPC_I, 3'd4, 7'h00);
    in_valid = 1'b1;
    edge_step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL rstmid_valid_pre: got %b want 1", out_valid); else n_pass++;
`endif
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || ALUControl !== 4'h0 || illegal !== 1'b0 || busy !== 1'b0 || md_start !== 1'b0)
      $display("FAIL rstmid_outputs: got valid=%b ctrl=%h ill=%b busy=%b md=%b want all 0",
               out_valid, ALUControl, illegal, busy, md_start); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < DIV_LAT + 8; i++) begin
      edge_step();
      if (out_valid === 1'b1) saw_valid = 1'b1;
    end
    n_checks++; if (saw_valid) $display("FAIL rstmid_no_valid: got out_valid=1 after reset want 0"); else n_pass++;
  endtask

  task automatic test_random();
    logic [6:0] opcs [4] = '{OPC_R, OPC_I, OPC_LD, OPC_BR};
    bit pend = 1'b0;
    logic [3:0] p_ctrl = 4'd0;
    logic p_ill = 1'b0;
    logic p_md = 1'b0;
    int p_lat = 0;
    int p_k = 0;
    int e = 0;
    bit exp_ov, exp_ir, acc, cons;
    logic [3:0] n_ctrl;
    logic n_ill, n_md;
    int n_lat, sel;
    in_valid = 1'b0; out_ready = 1'b1;
    edge_step();
    edge_step();
    for (int cyc = 0; cyc < 500; cyc++) begin
      exp_ov = pend && (e - p_k >= p_lat);
      n_checks++; if (out_valid !== exp_ov) $display("FAIL rnd_valid[%0d]: got %b want %b", cyc, out_valid, exp_ov); else n_pass++;
      n_checks++; if (busy !== (pend && p_md && (e - p_k < p_lat))) $display("FAIL rnd_busy[%0d]: got %b", cyc, busy); else n_pass++;
      n_checks++; if (md_start !== (pend && p_md && (e == p_k))) $display("FAIL rnd_md_start[%0d]: got %b", cyc, md_start); else n_pass++;
      if (exp_ov) begin
        n_checks++; if (ALUControl !== p_ctrl || illegal !== p_ill)
          $display("FAIL rnd_result[%0d]: got ctrl=%h ill=%b want ctrl=%h ill=%b", cyc, ALUControl, illegal, p_ctrl, p_ill); else n_pass++;
      end
      sel = $urandom_range(0, 9);
      set_op(2'($urandom_range(0, 3)), opcs[$urandom_range(0, 3)], 3'($urandom_range(0, 7)),
             (sel < 4) ? 7'h00 : (sel < 7) ? 7'h20 : (sel < 9) ? 7'h01 : 7'($urandom_range(0, 127)));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      exp_ir = !pend || (exp_ov && out_ready);
      n_checks++; if (in_ready !== exp_ir) $display("FAIL rnd_in_ready[%0d]: got %b want %b", cyc, in_ready, exp_ir); else n_pass++;
      acc  = in_valid && exp_ir;
      cons = exp_ov && out_ready;
      ref_dec(ALUop, op, funct3, funct7, n_ctrl, n_ill, n_md, n_lat);
      @(posedge clk);
      e++;
      if (cons) pend = 1'b0;
      if (acc) begin
        pend = 1'b1; p_k = e; p_ctrl = n_ctrl; p_ill = n_ill; p_md = n_md; p_lat = n_lat;
      end
      #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_stream();
    test_mul();
    test_backpressure();
    test_illegal();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
